// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      LOCK1 = 1'b1
   } state_t;

   localparam logic P_CPU = 1'b0;
   localparam logic P_AUX = 1'b1;

   localparam int BURST_W = 4;
   localparam int PERF_W  = 16;

endpackage

// File: rtl/dm_arb_rdret.sv
// Per-port read-return register: captures memory data on a granted read and
// raises rvalid for exactly the following cycle.
module dm_arb_rdret #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= capture;
         if (capture) rdata <= mem_dout;
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin data-memory arbiter with bounded port-1 burst locking.
// Optional DM_ARB_PERF_EN adds saturating stall counters and perf_clr.
//
// state | meaning
// IDLE  | round-robin between ports, tie goes to the port not in last
// LOCK1 | port 1 holds the memory while req1 & lock1, bounded by MAX_BURST
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int ADDR_W    = 7,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic [DATA_W-1:0] rdata0,
   output logic              rvalid0,
   output logic              stall0,
   input  logic              req1,
   input  logic              we1,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
`ifdef DM_ARB_PERF_EN
   input  logic              perf_clr,
   output logic [PERF_W-1:0] stall_cnt0,
   output logic [PERF_W-1:0] stall_cnt1,
`endif
   input  logic [DATA_W-1:0] mem_dout
);

   localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

   state_t             state_q, state_d;
   logic               last_q, last_d;
   logic [BURST_W-1:0] cnt_q, cnt_d;
   logic               g0, g1;
   logic               rr_sel;
   logic               forced;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= P_AUX;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      g0      = 1'b0;
      g1      = 1'b0;
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      rr_sel  = P_CPU;
      forced  = (state_q == LOCK1) && (cnt_q == MAX_B) && req0;

      if (req0 && req1) rr_sel = (last_q == P_CPU) ? P_AUX : P_CPU;
      else              rr_sel = req1 ? P_AUX : P_CPU;

      if (state_q == LOCK1 && req1 && lock1 && !forced) begin
         g1 = 1'b1;
      end else if (forced) begin
         g0 = 1'b1;
      end else if (req0 || req1) begin
         g1 = (rr_sel == P_AUX);
         g0 = (rr_sel == P_CPU);
      end

      if (rst) begin
         g0 = 1'b0;
         g1 = 1'b0;
      end

      if (g1) last_d = P_AUX;
      if (g0) last_d = P_CPU;

      // Burst count includes the entry grant so port 0 waits at most MAX_BURST.
      if (g1 && lock1) begin
         state_d = LOCK1;
         cnt_d   = ((state_q == IDLE) ? '0 : cnt_q) + {{(BURST_W-1){1'b0}}, req0};
      end else begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   assign gnt0     = g0;
   assign gnt1     = g1;
   assign stall0   = req0 & ~g0;
   assign mem_we   = g1 ? we1 : (we0 & g0);
   assign mem_addr = g1 ? addr1 : addr0;
   assign mem_din  = g1 ? wdata1 : wdata0;

   dm_arb_rdret #(.DATA_W(DATA_W)) u_rdret0 (
      .clk      (clk),
      .rst      (rst),
      .capture  (g0 & ~we0),
      .mem_dout (mem_dout),
      .rdata    (rdata0),
      .rvalid   (rvalid0)
   );

   dm_arb_rdret #(.DATA_W(DATA_W)) u_rdret1 (
      .clk      (clk),
      .rst      (rst),
      .capture  (g1 & ~we1),
      .mem_dout (mem_dout),
      .rdata    (rdata1),
      .rvalid   (rvalid1)
   );

`ifdef DM_ARB_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt0 <= '0;
         stall_cnt1 <= '0;
      end else if (perf_clr) begin
         stall_cnt0 <= '0;
         stall_cnt1 <= '0;
      end else begin
         if (stall0 && stall_cnt0 != '1)         stall_cnt0 <= stall_cnt0 + 1'b1;
         if (req1 && !g1 && stall_cnt1 != '1)    stall_cnt1 <= stall_cnt1 + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural dm model.
module tb_dm_arbiter;

   logic        clk;
   logic        rst;
   logic        req0, we0, req1, we1, lock1;
   logic [6:0]  addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, stall0;
   logic [31:0] rdata0, rdata1;
   logic        mem_we;
   logic [6:0]  mem_addr;
   logic [31:0] mem_din, mem_dout;
`ifdef DM_ARB_PERF_EN
   logic        perf_clr;
   logic [15:0] stall_cnt0, stall_cnt1;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mem [128];

   dm_arbiter #(.ADDR_W(7), .DATA_W(32), .MAX_BURST(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0),
      .we0      (we0),
      .addr0    (addr0),
      .wdata0   (wdata0),
      .gnt0     (gnt0),
      .rdata0   (rdata0),
      .rvalid0  (rvalid0),
      .stall0   (stall0),
      .req1     (req1),
      .we1      (we1),
      .lock1    (lock1),
      .addr1    (addr1),
      .wdata1   (wdata1),
      .gnt1     (gnt1),
      .rvalid1  (rvalid1),
      .rdata1   (rdata1),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
`ifdef DM_ARB_PERF_EN
      .perf_clr   (perf_clr),
      .stall_cnt0 (stall_cnt0),
      .stall_cnt1 (stall_cnt1),
`endif
      .mem_dout (mem_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // dm model: asynchronous read, synchronous write, known contents on reset.
   assign mem_dout = mem[mem_addr];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
         mem[5] <= 32'hDEADBEEF;
      end else if (mem_we) begin
         mem[mem_addr] <= mem_din;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
      req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
   endtask

   task automatic do_reset();
      cyc();
      rst = 1;
      idle_inputs();
      cyc();
      rst = 0;
   endtask

   logic [3:0] pat_rr;
   logic [9:0] pat_lk;

   initial begin
      rst = 1;
      idle_inputs();
`ifdef DM_ARB_PERF_EN
      perf_clr = 0;
`endif
      req0 = 1; req1 = 1;
      #7;
      chk("rst_gnt0", {31'b0, gnt0}, 32'd0);
      chk("rst_gnt1", {31'b0, gnt1}, 32'd0);
      chk("rst_rvalid0", {31'b0, rvalid0}, 32'd0);
      chk("rst_rvalid1", {31'b0, rvalid1}, 32'd0);
      chk("rst_rdata0", rdata0, 32'd0);
      chk("rst_rdata1", rdata1, 32'd0);

      // Single uncontended CPU read of addr 5
      cyc();
      rst = 0;
      idle_inputs();
      req0 = 1; addr0 = 7'd5;
      #4;
      chk("rd_gnt0", {31'b0, gnt0}, 32'd1);
      chk("rd_gnt1", {31'b0, gnt1}, 32'd0);
      chk("rd_stall0", {31'b0, stall0}, 32'd0);
      chk("rd_addr", {25'b0, mem_addr}, 32'd5);
      chk("rd_we", {31'b0, mem_we}, 32'd0);
      cyc();
      req0 = 0;
      #4;
      chk("rd_rvalid0", {31'b0, rvalid0}, 32'd1);
      chk("rd_rdata0", rdata0, 32'hDEADBEEF);
      chk("rd_rvalid1", {31'b0, rvalid1}, 32'd0);
      cyc();
      #4;
      chk("rd_rvalid0_drop", {31'b0, rvalid0}, 32'd0);
      chk("rd_rdata0_hold", rdata0, 32'hDEADBEEF);

      // Round-robin from reset: 0,1,0,1
      do_reset();
      pat_rr = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) cyc();
         req0 = 1; req1 = 1; addr0 = 7'd1; addr1 = 7'd2;
         #4;
         chk($sformatf("rr_gnt0_c%0d", i + 1), {31'b0, gnt0}, {31'b0, pat_rr[i]});
         chk($sformatf("rr_gnt1_c%0d", i + 1), {31'b0, gnt1}, {31'b0, ~pat_rr[i]});
         chk($sformatf("rr_stall0_c%0d", i + 1), {31'b0, stall0}, {31'b0, ~pat_rr[i]});
      end

      // Point last at port 0 so port 1 wins the first locked tie
      cyc();
      idle_inputs();
      req0 = 1;
      #4;
      chk("pre_lock_gnt0", {31'b0, gnt0}, 32'd1);

      pat_lk = 10'b0111101111;
      for (int i = 0; i < 10; i++) begin
         cyc();
         req0 = 1; req1 = 1; lock1 = 1; addr0 = 7'd9; addr1 = 7'd10;
         #4;
         chk($sformatf("lk_gnt1_c%0d", i + 1), {31'b0, gnt1}, {31'b0, pat_lk[i]});
         chk($sformatf("lk_gnt0_c%0d", i + 1), {31'b0, gnt0}, {31'b0, ~pat_lk[i]});
         chk($sformatf("lk_addr_c%0d", i + 1), {25'b0, mem_addr},
             pat_lk[i] ? 32'd10 : 32'd9);
      end

      // Port-1 write then port-0 read of the same word
      cyc();
      idle_inputs();
      req1 = 1; we1 = 1; addr1 = 7'd3; wdata1 = 32'h12345678;
      #4;
      chk("wr_gnt1", {31'b0, gnt1}, 32'd1);
      chk("wr_mem_we", {31'b0, mem_we}, 32'd1);
      chk("wr_mem_addr", {25'b0, mem_addr}, 32'd3);
      chk("wr_mem_din", mem_din, 32'h12345678);
      cyc();
      idle_inputs();
      req0 = 1; addr0 = 7'd3;
      #4;
      chk("rb_gnt0", {31'b0, gnt0}, 32'd1);
      chk("rb_mem_we", {31'b0, mem_we}, 32'd0);
      chk("wr_no_rvalid1", {31'b0, rvalid1}, 32'd0);
      cyc();
      idle_inputs();
      #4;
      chk("rb_rvalid0", {31'b0, rvalid0}, 32'd1);
      chk("rb_rdata0", rdata0, 32'h12345678);
      chk("rb_mem_we_idle", {31'b0, mem_we}, 32'd0);

      // Reset right after a granted locked port-1 read
      cyc();
      req1 = 1; lock1 = 1; addr1 = 7'd5;
      #4;
      chk("rr1_gnt1", {31'b0, gnt1}, 32'd1);
      cyc();
      rst = 1;
      idle_inputs();
      #4;
      chk("rst_drop_rvalid1", {31'b0, rvalid1}, 32'd0);
      chk("rst_drop_rdata1", rdata1, 32'd0);
      cyc();
      rst = 0;
      req0 = 1; req1 = 1; lock1 = 1;
      #4;
      chk("post_rst_gnt0", {31'b0, gnt0}, 32'd1);
      chk("post_rst_gnt1", {31'b0, gnt1}, 32'd0);

`ifdef DM_ARB_PERF_EN
      do_reset();
      req1 = 1; lock1 = 1;
      #4;
      chk("pf_entry_gnt1", {31'b0, gnt1}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         req0 = 1; req1 = 1; lock1 = 1;
         #4;
         chk($sformatf("pf_stall_c%0d", i + 1), {31'b0, stall0}, 32'd1);
      end
      cyc();
      idle_inputs();
      #4;
      chk("pf_cnt0_3", {16'b0, stall_cnt0}, 32'd3);
      chk("pf_cnt1_0", {16'b0, stall_cnt1}, 32'd0);
      cyc();
      perf_clr = 1;
      cyc();
      perf_clr = 0;
      #4;
      chk("pf_cnt0_clr", {16'b0, stall_cnt0}, 32'd0);
      // Locked bursts stall port 0 four cycles in five: 85000 cycles > 65535 stalls
      cyc();
      req0 = 1; req1 = 1; lock1 = 1;
      repeat (85000) @(posedge clk);
      #1;
      idle_inputs();
      #4;
      chk("pf_cnt0_sat", {16'b0, stall_cnt0}, 32'h0000FFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter that shares the single-port data memory (`dm`, synchronous write, asynchronous read) between the CPU data port and a secondary master: program loader, debug or DMA. It sits between `sccpu` and `dm` inside the top level. It performs one access per cycle using round-robin arbitration with bounded burst locking, and returns registered read data with a valid strobe. A CPU stall output lets the pipeline freeze its MEM stage while it waits.

## Interface
Parameters:
- `ADDR_W`, default 7, word-address width (matches the `dm` address, byte address bits [8:2]).
- `DATA_W`, default 32, data width.
- `MAX_BURST`, default 4, maximum consecutive locked grants to port 1 while port 0 is waiting; range 1..15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0`, `we0` in 1 each: CPU request and write-enable.
- `addr0` in ADDR_W; `wdata0` in DATA_W: CPU address and write data.
- `gnt0` out 1: CPU access performed this cycle.
- `rdata0` out DATA_W; `rvalid0` out 1: CPU read data and its valid strobe.
- `stall0` out 1: `req0 & ~gnt0`.
- `req1`, `we1`, `lock1` in 1 each: port-1 request, write-enable and burst lock.
- `addr1` in ADDR_W; `wdata1` in DATA_W: port-1 address and write data.
- `gnt1`, `rvalid1` out 1 each; `rdata1` out DATA_W: port-1 grant, read strobe and read data.
- `mem_we` out 1; `mem_addr` out ADDR_W; `mem_din` out DATA_W: to `dm`.
- `mem_dout` in DATA_W: from `dm`.

## Operation
- Grants are combinational from the requests and registered state. At most one grant is high per cycle, and a grant is never issued without its request.
- The memory mux selects the granted port. `mem_we = we_g & gnt_g`. With no grant, `mem_we=0` and the address and data are don't-care but driven from port 0.
- FSM states:
  - IDLE (round-robin): if only one port requests, grant it. If both request, grant the port not equal to the `last` pointer. `last` updates to the granted port.
  - LOCK1: entered when port 1 is granted with `lock1=1`. Port 1 wins every cycle while `req1 & lock1`. `burst_cnt` counts locked grants made while `req0=1`.
  - LOCK1 exits to IDLE when `lock1=0`, `req1=0`, or `burst_cnt==MAX_BURST` with `req0=1`.
  - On a forced exit, the next cycle grants port 0 and sets `last=0`. `burst_cnt` clears on entering IDLE.
- Port 0 has no lock: the CPU issues single beats.
- Read return: on a granted read, `mem_dout` is captured into `rdata_g` at the edge. `rvalid_g` is high the following cycle only. On a granted write, `rvalid` stays low and `rdata` holds.
- Simultaneous requests to the same address cannot collide: accesses are serialized by grant order.
- Reset values:
  - State IDLE, `last=1`, so port 0 wins the first tie.
  - `burst_cnt=0`, `rvalid0=rvalid1=0`, `rdata0=rdata1=0`.
  - Grants are low during reset regardless of requests.
- Reset during an operation: an access in flight is dropped, with no `rvalid` afterwards. A write already clocked into `dm` remains.

## Timing
- Grant latency is 0 cycles for an uncontended request.
- Read data is valid 1 cycle after the grant.
- Worst-case port 0 wait is `MAX_BURST` cycles. Worst-case port 1 wait is 1 cycle.
- `stall0` is combinational. It must be stable before the CPU's pipeline-register enable by the end of the cycle.

## Configuration
- `DM_ARB_PERF_EN`: when defined, adds two 16-bit saturating counters, `stall_cnt0` (cycles with `stall0`) and `stall_cnt1` (cycles with `req1 & ~gnt1`).
  - Exposed as outputs `stall_cnt0` and `stall_cnt1`.
  - Reset to 0; they saturate at 16'hFFFF.
  - `perf_clr` input (1 bit, synchronous) clears both counters.
- When `DM_ARB_PERF_EN` is undefined, those ports and the logic are absent and the arbiter behaviour is identical.

## Structure
- Shared package `dm_arb_pkg`:
  - State enum (IDLE, LOCK1).
  - Port-index constants (`P_CPU=0`, `P_AUX=1`).
  - Counter width constant for the perf counters.
- One natural sub-module, `dm_arb_rdret`: per-port read-return register (capture on a granted read, one-cycle `rvalid`), instantiated twice.

## Test plan
- Reset then `req0` read of addr 5 with `mem_dout=32'hDEADBEEF` -> `gnt0=1` in the same cycle; next cycle `rvalid0=1`, `rdata0=32'hDEADBEEF`, `stall0=0`.
- `req0` and `req1` both high from reset for 4 cycles -> grants alternate 0,1,0,1; `stall0` is high in cycles 2 and 4 only.
- `req1` with `lock1` held for 10 cycles while `req0` is held, `MAX_BURST=4` -> `gnt1` for 4 cycles, `gnt0` on cycle 5, then port 1 relocks.
- Port-1 write of 32'h12345678 to addr 3, then a port-0 read of addr 3 -> `mem_we` is high only in the write cycle; `rdata0=32'h12345678`.
- Assert `rst` in the cycle after a granted port-1 read -> `rvalid1` stays 0, state is IDLE, and the next tie grants port 0.
- With `DM_ARB_PERF_EN` defined, 3 stalled CPU cycles then `perf_clr` -> `stall_cnt0` reads 3 and then 0; forcing 70000 stall cycles -> `stall_cnt0` holds at 16'hFFFF.
